scsp_dma_ctrl: RTL

- Sequences SCSP DMA transfers between sound RAM and the SCSP register/DSP space, driven by the CR5/CR6/CR7 fields DMEA, DRGA, DTLG, DDIR, DGATE and DEXE.
- Sits between the register file, which supplies the config and start pulse, and two request/ready ports: the sound-RAM arbiter and the internal register bus.
- Clears DEXE on completion and pulses the DMA-end interrupt source into the SCIPD/MCIPD logic.

---
 rtl/scsp_dma_ctrl_pkg.sv | 26 ++
 rtl/scsp_dma_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/scsp_dma_ctrl_pkg.sv
// Shared types and constants for the SCSP DMA sequencer: FSM state encoding,
// the CR5..CR7 configuration snapshot and the DMA-end interrupt index.
package scsp_dma_ctrl_pkg;

    localparam int DMA_RAM_AW  = 19;
    localparam int DMA_REG_AW  = 11;
    localparam int DMA_LEN_W   = 11;
    localparam int DMA_IRQ_BIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        NEXT,
        DONE
    } DMAState_t;

    typedef struct packed {
        logic [DMA_RAM_AW-1:0] dmea;
        logic [DMA_REG_AW-1:0] drga;
        logic [DMA_LEN_W-1:0]  dtlg;
        logic                  ddir;
        logic                  dgate;
    } DMACfg_t;

endpackage

// File: rtl/scsp_dma_ctrl.sv
// SCSP DMA sequencer: copies DTLG words between sound RAM and register space.
// Optional macro SCSP_DMA_ABORT_EN lets DEXE_CLR stop a transfer after the current word.
module scsp_dma_ctrl
    import scsp_dma_ctrl_pkg::*;
#(
    parameter int RAM_AW = DMA_RAM_AW,
    parameter int REG_AW = DMA_REG_AW,
    parameter int LEN_W  = DMA_LEN_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE,
    input  logic [RAM_AW-1:0] DMEA,
    input  logic [REG_AW-1:0] DRGA,
    input  logic [LEN_W-1:0]  DTLG,
    input  logic              DDIR,
    input  logic              DGATE,
    input  logic              DEXE_SET,
    input  logic              DEXE_CLR,
    output logic              DEXE,
    output logic              DMA_END,
    output logic [RAM_AW-1:0] MEM_A,
    output logic [15:0]       MEM_D,
    input  logic [15:0]       MEM_Q,
    output logic              MEM_RD,
    output logic              MEM_WR,
    input  logic              MEM_RDY,
    output logic [REG_AW-1:0] REG_A,
    output logic [15:0]       REG_D,
    input  logic [15:0]       REG_Q,
    output logic              REG_RD,
    output logic              REG_WR,
    input  logic              REG_RDY
);

    DMAState_t         state_reg, state_next;
    logic [RAM_AW-1:0] mem_addr_reg, mem_addr_next;
    logic [REG_AW-1:0] reg_addr_reg, reg_addr_next;
    logic [LEN_W-1:0]  count_reg, count_next;
    logic [15:0]       data_reg, data_next;
    logic              ddir_reg, ddir_next;
    logic              dgate_reg, dgate_next;
    logic              dexe_reg, dexe_next;

    DMACfg_t           start_cfg;
    logic              src_rdy;
    logic              dst_rdy;
    logic [15:0]       src_q;
    logic [15:0]       wr_data;
    logic              abort_req;

`ifdef SCSP_DMA_ABORT_EN
    logic abort_reg;

    // The flag only matters while a transfer is in flight; it is dropped on completion.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            abort_reg <= 1'b0;
        end else if (CE) begin
            abort_reg <= (state_reg == DONE || state_reg == IDLE) ? 1'b0 : abort_req;
        end
    end

    assign abort_req = abort_reg | (DEXE_CLR & dexe_reg & (state_reg != DONE));
`else
    logic unused_dexe_clr;
    assign unused_dexe_clr = DEXE_CLR;
    assign abort_req       = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= IDLE;
            mem_addr_reg <= '0;
            reg_addr_reg <= '0;
            count_reg    <= '0;
            data_reg     <= '0;
            ddir_reg     <= 1'b0;
            dgate_reg    <= 1'b0;
            dexe_reg     <= 1'b0;
        end else if (CE) begin
            state_reg    <= state_next;
            mem_addr_reg <= mem_addr_next;
            reg_addr_reg <= reg_addr_next;
            count_reg    <= count_next;
            data_reg     <= data_next;
            ddir_reg     <= ddir_next;
            dgate_reg    <= dgate_next;
            dexe_reg     <= dexe_next;
        end
    end

    // Source is RAM for DDIR=0 and the register bus for DDIR=1; destination is the other side.
    assign src_rdy = ddir_reg ? REG_RDY : MEM_RDY;
    assign dst_rdy = ddir_reg ? MEM_RDY : REG_RDY;
    assign src_q   = ddir_reg ? REG_Q   : MEM_Q;

    always_comb begin
        state_next    = state_reg;
        mem_addr_next = mem_addr_reg;
        reg_addr_next = reg_addr_reg;
        count_next    = count_reg;
        data_next     = data_reg;
        ddir_next     = ddir_reg;
        dgate_next    = dgate_reg;
        dexe_next     = dexe_reg;
        start_cfg     = {DMEA, DRGA, DTLG, DDIR, DGATE};

        case (state_reg)
            IDLE: begin
                if (DEXE_SET) begin
                    dexe_next     = 1'b1;
                    mem_addr_next = start_cfg.dmea;
                    reg_addr_next = start_cfg.drga;
                    count_next    = start_cfg.dtlg;
                    ddir_next     = start_cfg.ddir;
                    dgate_next    = start_cfg.dgate;
                    if (start_cfg.dtlg == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = start_cfg.dgate ? WR : RD;
                    end
                end
            end
            RD: begin
                if (src_rdy) begin
                    data_next  = src_q;
                    state_next = WR;
                end
            end
            WR: begin
                if (dst_rdy) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                mem_addr_next = mem_addr_reg + RAM_AW'(1);
                reg_addr_next = reg_addr_reg + REG_AW'(1);
                count_next    = count_reg - LEN_W'(1);
                if (count_reg == LEN_W'(1) || abort_req) begin
                    state_next = DONE;
                end else begin
                    state_next = dgate_reg ? WR : RD;
                end
            end
            DONE: begin
                dexe_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Requests decode straight from the state register so they fall with the async reset.
    assign wr_data = dgate_reg ? 16'h0000 : data_reg;
    assign MEM_RD  = (state_reg == RD) & ~ddir_reg;
    assign REG_RD  = (state_reg == RD) &  ddir_reg;
    assign MEM_WR  = (state_reg == WR) &  ddir_reg;
    assign REG_WR  = (state_reg == WR) & ~ddir_reg;
    assign MEM_A   = mem_addr_reg;
    assign REG_A   = reg_addr_reg;
    assign MEM_D   = wr_data;
    assign REG_D   = wr_data;
    assign DEXE    = dexe_reg;
    assign DMA_END = (state_reg == DONE);

endmodule
